// File: rtl/jpeg_dma_wr_if.sv
// Wishbone bus bundle used by the JPEG DMA masters.
// Master drives address/data/strobes; slave returns data, ack and err.
interface wishbone;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic        cyc;
   logic [31:0] dat_i;
   logic        ack;
   logic        err;

   modport master (
      output adr, dat_o, sel, we, stb, cyc,
      input  dat_i, ack, err
   );

   modport slave (
      input  adr, dat_o, sel, we, stb, cyc,
      output dat_i, ack, err
   );
endinterface

// File: rtl/jpeg_dma_wr.sv
// Write-direction DMA: drains the output block RAM into a
// software-programmed memory buffer as a Wishbone master.
module jpeg_dma_wr #(
   parameter int BURST_LEN = 8,
   parameter int ADDR_W    = 9
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic              wb_we_i,
   output logic [31:0]       wb_dat_o,
   input  logic              dmaen_i,
   wishbone.master           wbm,
   output logic [ADDR_W-1:0] obram_addr,
   input  logic [31:0]       obram_data,
   output logic              done_o
);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, WRITE, RELEASE, DONE
   } state_e;

   state_e        state_q, state_d;
   logic [31:2]   dst_q, dst_d;
   logic [9:0]    len_q, len_d;
   logic [9:0]    cnt_q, cnt_d;
   logic [9:0]    cnt_inc;
   logic [BW-1:0] beat_q, beat_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          abort_q, abort_d;
   logic          zlen_q, zlen_d;
   logic          wr, wr_dst, wr_len, wr_ctl;
   logic          start, abort, abort_now, busy;
   logic          unused_ok;

   assign wr        = dmaen_i & wb_we_i;
   assign wr_dst    = wr & (wb_adr_i[4:2] == 3'd0);
   assign wr_len    = wr & (wb_adr_i[4:2] == 3'd1);
   assign wr_ctl    = wr & (wb_adr_i[4:2] == 3'd2);
   assign start     = wr_ctl & wb_dat_i[0];
   assign abort     = wr_ctl & wb_dat_i[1];
   assign abort_now = abort_q | abort;
   assign busy      = (state_q != IDLE);
   assign cnt_inc   = cnt_q + 10'd1;

   assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], wbm.dat_i};

   always_comb begin
      wb_dat_o = 32'h0;
      case (wb_adr_i[4:2])
         3'd0:    wb_dat_o = {dst_q, 2'b00};
         3'd1:    wb_dat_o = {22'h0, len_q};
         3'd2:    wb_dat_o = {14'h0, cnt_q, 5'h0,
                              err_q, done_q, busy};
         default: wb_dat_o = 32'h0;
      endcase
   end

   assign wbm.adr   = {dst_q, 2'b00} + {20'h0, cnt_q, 2'b00};
   assign wbm.dat_o = obram_data;
   assign wbm.sel   = 4'hF;
   assign wbm.we    = 1'b1;
   assign wbm.stb   = (state_q == WRITE);
   // cyc stays up across the fetch gap of every beat but the first
   assign wbm.cyc   = (state_q == WRITE) ||
                      ((state_q == FETCH) && (cnt_q != 10'd0));
   assign obram_addr = cnt_q[ADDR_W-1:0];
   assign done_o     = (state_q == DONE) | zlen_q;

   always_comb begin
      state_d = state_q;
      dst_d   = dst_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      done_d  = done_q;
      err_d   = err_q;
      abort_d = abort_q;
      zlen_d  = 1'b0;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (wr_dst) dst_d = wb_dat_i[31:2];
            if (wr_len) len_d = wb_dat_i[9:0];
            if (start) begin
               cnt_d  = 10'd0;
               beat_d = '0;
               done_d = 1'b0;
               err_d  = 1'b0;
               if (len_q == 10'd0) begin
                  done_d = 1'b1;
                  zlen_d = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            state_d = abort ? IDLE : WRITE;
         end
         WRITE: begin
            if (abort) abort_d = 1'b1;
            if (wbm.err) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (wbm.ack) begin
               cnt_d  = cnt_inc;
               beat_d = beat_q + BW'(1);
               if (abort_now)               state_d = IDLE;
               else if (cnt_inc == len_q)   state_d = DONE;
               else if (beat_q == BEAT_LAST) state_d = RELEASE;
               else                         state_d = FETCH;
            end
         end
         RELEASE: begin
            beat_d  = '0;
            state_d = abort ? IDLE : FETCH;
         end
         DONE: begin
            done_d  = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         dst_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         zlen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         err_q   <= err_d;
         abort_q <= abort_d;
         zlen_q  <= zlen_d;
      end
   end
endmodule

// File: tb/tb_jpeg_dma_wr.sv
// Directed bench for jpeg_dma_wr: Wishbone slave and block RAM
// models, one task per scenario with inline expected-value checks.
module tb_jpeg_dma_wr;
   logic        clk;
   logic        rst_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_we_i;
   logic [31:0] wb_dat_o;
   logic        dmaen_i;
   logic [8:0]  obram_addr;
   logic [31:0] obram_data;
   logic        done_o;

   wishbone wbm ();

   jpeg_dma_wr #(.BURST_LEN(8), .ADDR_W(9)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_we_i    (wb_we_i),
      .wb_dat_o   (wb_dat_o),
      .dmaen_i    (dmaen_i),
      .wbm        (wbm),
      .obram_addr (obram_addr),
      .obram_data (obram_data),
      .done_o     (done_o)
   );

   int n_assert = 0;
   int n_fail   = 0;

   int waits, err_at, n_ack, n_beat, wcnt;
   int unstable, done_cnt, cyc_cycles;
   int ndrop, low_run;
   int drop_at [8];
   int drop_len [8];
   bit hold_ack, cyc_prev;
   logic [31:0] hold_a, hold_d;
   logic [31:0] wr_adr [64];
   logic [31:0] wr_dat [64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ram_word(input logic [8:0] a);
      return 32'hD000_0000 + ({23'h0, a} * 32'h0001_0001);
   endfunction

   always @(posedge clk) obram_data <= ram_word(obram_addr);

   // Wishbone slave model and bus monitor
   always @(negedge clk) begin
      wbm.ack = 1'b0;
      wbm.err = 1'b0;
      if (done_o) done_cnt++;
      if (wbm.cyc) cyc_cycles++;
      if (cyc_prev && !wbm.cyc) begin
         if (ndrop < 8) drop_at[ndrop] = n_ack;
         ndrop++;
         low_run = 0;
      end
      if (!wbm.cyc) low_run++;
      if (!cyc_prev && wbm.cyc && ndrop > 0 && ndrop <= 8)
         if (drop_len[ndrop-1] == 0) drop_len[ndrop-1] = low_run;
      cyc_prev = wbm.cyc;
      if (wbm.stb) begin
         if (wcnt != 0 && (wbm.adr !== hold_a || wbm.dat_o !== hold_d))
            unstable++;
         hold_a = wbm.adr;
         hold_d = wbm.dat_o;
         if (!hold_ack && wcnt >= waits) begin
            if (n_beat == err_at) begin
               wbm.err = 1'b1;
            end else begin
               wbm.ack = 1'b1;
               if (n_ack < 64) begin
                  wr_adr[n_ack] = wbm.adr;
                  wr_dat[n_ack] = wbm.dat_o;
               end
               n_ack++;
            end
            n_beat++;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic clear_mon();
      @(posedge clk); #1;
      n_ack = 0; n_beat = 0; wcnt = 0; unstable = 0;
      done_cnt = 0; cyc_cycles = 0; ndrop = 0; low_run = 0;
      for (int i = 0; i < 8; i++) begin
         drop_at[i] = 0;
         drop_len[i] = 0;
      end
   endtask

   task automatic reg_write(input int idx, input logic [31:0] d);
      @(posedge clk); #1;
      wb_adr_i = 32'(idx) << 2;
      wb_dat_i = d;
      wb_we_i  = 1'b1;
      dmaen_i  = 1'b1;
      @(posedge clk); #1;
      wb_we_i  = 1'b0;
      dmaen_i  = 1'b0;
   endtask

   task automatic reg_read(input int idx, output logic [31:0] d);
      wb_adr_i = 32'(idx) << 2;
      #1;
      d = wb_dat_o;
   endtask

   task automatic wait_idle(input int maxc);
      logic [31:0] s;
      int k;
      k = 0;
      reg_read(2, s);
      while (s[0] && k < maxc) begin
         @(posedge clk); #1;
         reg_read(2, s);
         k++;
      end
      n_assert++;
      if (s[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, want 0",
                  s[0], maxc);
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      n_assert++;
      if (wbm.cyc !== 1'b0 || wbm.stb !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cyc_stb: got %b%b want 00", wbm.cyc, wbm.stb);
      end
      n_assert++;
      if (wbm.we !== 1'b1 || wbm.sel !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_we_sel: got %b/%h want 1/f", wbm.we, wbm.sel);
      end
      n_assert++;
      if (obram_addr !== 9'd0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_addr_done: got %h/%b want 0/0",
                  obram_addr, done_o);
      end
      reg_read(0, r);
      n_assert++;
      if (r !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dstaddr: got %h want 0", r);
      end
      reg_read(1, r);
      n_assert++;
      if (r !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_len: got %h want 0", r);
      end
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_stat: got %h want 0", r);
      end
   endtask

   task automatic test_basic();
      logic [31:0] r;
      clear_mon();
      reg_write(0, 32'h0000_1003);
      reg_write(1, 32'd3);
      reg_read(0, r);
      n_assert++;
      if (r !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL basic_dst_rb: got %h want 00001000", r);
      end
      reg_read(1, r);
      n_assert++;
      if (r !== 32'd3) begin
         n_fail++;
         $display("FAIL basic_len_rb: got %h want 3", r);
      end
      reg_write(2, 32'h1);
      wait_idle(200);
      n_assert++;
      if (n_ack !== 3) begin
         n_fail++;
         $display("FAIL basic_nwrites: got %0d want 3", n_ack);
      end
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (wr_adr[i] !== 32'h1000 + 32'(4 * i) ||
             wr_dat[i] !== ram_word(9'(i))) begin
            n_fail++;
            $display("FAIL basic_beat%0d: got %h/%h want %h/%h", i,
                     wr_adr[i], wr_dat[i], 32'h1000 + 32'(4 * i),
                     ram_word(9'(i)));
         end
      end
      n_assert++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL basic_done_o: got %0d pulses want 1", done_cnt);
      end
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0000_0302) begin
         n_fail++;
         $display("FAIL basic_stat: got %h want 00000302", r);
      end
   endtask

   task automatic test_burst();
      logic [31:0] r;
      clear_mon();
      reg_write(0, 32'h0000_2000);
      reg_write(1, 32'd20);
      reg_write(2, 32'h1);
      wait_idle(1000);
      n_assert++;
      if (n_ack !== 20) begin
         n_fail++;
         $display("FAIL burst_nwrites: got %0d want 20", n_ack);
      end
      n_assert++;
      if (ndrop !== 3) begin
         n_fail++;
         $display("FAIL burst_ndrop: got %0d want 3", ndrop);
      end
      n_assert++;
      if (drop_at[0] !== 8 || drop_len[0] !== 1) begin
         n_fail++;
         $display("FAIL burst_gap1: got at %0d len %0d want at 8 len 1",
                  drop_at[0], drop_len[0]);
      end
      n_assert++;
      if (drop_at[1] !== 16 || drop_len[1] !== 1) begin
         n_fail++;
         $display("FAIL burst_gap2: got at %0d len %0d want at 16 len 1",
                  drop_at[1], drop_len[1]);
      end
      n_assert++;
      if (drop_at[2] !== 20) begin
         n_fail++;
         $display("FAIL burst_end: got at %0d want at 20", drop_at[2]);
      end
      n_assert++;
      if (wr_adr[19] !== 32'h204C || wr_dat[19] !== ram_word(9'd19)) begin
         n_fail++;
         $display("FAIL burst_last: got %h/%h want 0000204c/%h",
                  wr_adr[19], wr_dat[19], ram_word(9'd19));
      end
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0000_1402) begin
         n_fail++;
         $display("FAIL burst_stat: got %h want 00001402", r);
      end
   endtask

   task automatic test_wait_states();
      clear_mon();
      waits = 3;
      reg_write(0, 32'h0000_3000);
      reg_write(1, 32'd4);
      reg_write(2, 32'h1);
      wait_idle(500);
      waits = 0;
      n_assert++;
      if (unstable !== 0) begin
         n_fail++;
         $display("FAIL wait_stable: got %0d changes want 0", unstable);
      end
      n_assert++;
      if (cyc_cycles !== 19) begin
         n_fail++;
         $display("FAIL wait_cyc_len: got %0d want 19", cyc_cycles);
      end
      n_assert++;
      if (n_ack !== 4) begin
         n_fail++;
         $display("FAIL wait_nwrites: got %0d want 4", n_ack);
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (wr_adr[i] !== 32'h3000 + 32'(4 * i) ||
             wr_dat[i] !== ram_word(9'(i))) begin
            n_fail++;
            $display("FAIL wait_beat%0d: got %h/%h want %h/%h", i,
                     wr_adr[i], wr_dat[i], 32'h3000 + 32'(4 * i),
                     ram_word(9'(i)));
         end
      end
   endtask

   task automatic test_bus_error();
      logic [31:0] r;
      clear_mon();
      err_at = 4;
      reg_write(0, 32'h0000_4000);
      reg_write(1, 32'd10);
      reg_write(2, 32'h1);
      wait_idle(500);
      err_at = -1;
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0000_0404) begin
         n_fail++;
         $display("FAIL err_stat: got %h want 00000404", r);
      end
      n_assert++;
      if (done_cnt !== 0 || n_ack !== 4) begin
         n_fail++;
         $display("FAIL err_done_acks: got %0d/%0d want 0/4",
                  done_cnt, n_ack);
      end
      clear_mon();
      reg_write(1, 32'd2);
      reg_write(2, 32'h1);
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL err_cleared: got %h want 00000001", r);
      end
      wait_idle(200);
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0000_0202 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL err_rerun: got %h/%0d want 00000202/1",
                  r, done_cnt);
      end
   endtask

   task automatic test_abort();
      logic [31:0] r;
      int k;
      clear_mon();
      hold_ack = 1'b1;
      reg_write(0, 32'h0000_5000);
      reg_write(1, 32'd6);
      reg_write(2, 32'h1);
      k = 0;
      while (wbm.stb !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      n_assert++;
      if (wbm.stb !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_stb_rise: got %b want 1", wbm.stb);
      end
      reg_write(2, 32'h2);
      repeat (2) @(posedge clk);
      #1;
      n_assert++;
      if (wbm.stb !== 1'b1 || wbm.adr !== 32'h5000) begin
         n_fail++;
         $display("FAIL abort_stb_held: got %b/%h want 1/00005000",
                  wbm.stb, wbm.adr);
      end
      hold_ack = 1'b0;
      wait_idle(100);
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0000_0100) begin
         n_fail++;
         $display("FAIL abort_stat: got %h want 00000100", r);
      end
      n_assert++;
      if (n_ack !== 1 || done_cnt !== 0) begin
         n_fail++;
         $display("FAIL abort_acks_done: got %0d/%0d want 1/0",
                  n_ack, done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      int k;
      clear_mon();
      waits = 2;
      reg_write(0, 32'h0000_6000);
      reg_write(1, 32'd20);
      reg_write(2, 32'h1);
      k = 0;
      while (n_ack < 3 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      n_assert++;
      if (n_ack < 3) begin
         n_fail++;
         $display("FAIL rst_progress: got %0d acks want >=3", n_ack);
      end
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      waits = 0;
      n_assert++;
      if (wbm.cyc !== 1'b0 || wbm.stb !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_bus: got %b%b want 00", wbm.cyc, wbm.stb);
      end
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_stat: got %h want 0", r);
      end
      clear_mon();
      reg_write(2, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      n_assert++;
      if (done_cnt !== 1 || cyc_cycles !== 0) begin
         n_fail++;
         $display("FAIL zero_len: got %0d pulses %0d cyc want 1/0",
                  done_cnt, cyc_cycles);
      end
      reg_read(2, r);
      n_assert++;
      if (r !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL zero_len_stat: got %h want 00000002", r);
      end
   endtask

   initial begin
      rst_i       = 1'b1;
      wb_adr_i    = 32'h0;
      wb_dat_i    = 32'h0;
      wb_we_i     = 1'b0;
      dmaen_i     = 1'b0;
      wbm.ack     = 1'b0;
      wbm.err     = 1'b0;
      wbm.dat_i   = 32'h0;
      waits       = 0;
      err_at      = -1;
      hold_ack    = 1'b0;
      cyc_prev    = 1'b0;
      n_ack       = 0;
      n_beat      = 0;
      wcnt        = 0;
      unstable    = 0;
      done_cnt    = 0;
      cyc_cycles  = 0;
      ndrop       = 0;
      low_run     = 0;
      hold_a      = 32'h0;
      hold_d      = 32'h0;
      test_reset();
      test_basic();
      test_burst();
      test_wait_states();
      test_bus_error();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
